// File: rtl/asteroid_pkg.sv
// Shared definitions for the asteroid shape-code interface (generator and decoder side).
package asteroid_pkg;

  localparam int SHAPE_CODE_W = 3;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;

  typedef logic [SHAPE_CODE_W-1:0] shape_code_t;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PRESENT
  } gen_state_t;

  // Bump a shape to its neighbour once it has already appeared maxRep times in a row.
  function automatic shape_code_t limitRepeat(
    input shape_code_t raw,
    input shape_code_t lastCode,
    input logic [2:0]  repeatCnt,
    input logic [2:0]  maxRep
  );
    if ((raw == lastCode) && (repeatCnt == maxRep)) begin
      return raw + shape_code_t'(1);
    end
    return raw;
  endfunction

endpackage

// File: rtl/galois_lfsr16.sv
// Free-running 16-bit right-shift Galois LFSR; a zero seed is forced to 1 so it never locks up.
module galois_lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  input  logic [15:0] taps,
  output logic [15:0] value
);

  logic [15:0] r_value;
  logic [15:0] w_seedSafe;

  assign w_seedSafe = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= w_seedSafe;
    end else begin
      r_value <= (r_value >> 1) ^ (r_value[0] ? taps : 16'h0000);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/asteroid_code_generator.sv
// Spawns random asteroid shape codes on a tick-driven interval and offers them on valid/ready.
module asteroid_code_generator
  import asteroid_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = DEFAULT_LFSR_SEED,
  parameter logic [15:0] LFSR_TAPS  = DEFAULT_LFSR_TAPS,
  parameter int          MAX_REPEAT = 2,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             tick,
  input  logic [CNT_W-1:0] spawn_period,
  input  logic             code_ready,
  output shape_code_t      code_out,
  output logic             code_valid,
  output logic             overrun,
  output logic [15:0]      spawn_count
);

  localparam logic [2:0] MAX_REP = 3'(MAX_REPEAT);

  gen_state_t       r_state;
  gen_state_t       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] w_effLast;
  shape_code_t      r_code;
  shape_code_t      r_lastCode;
  logic [2:0]       r_repeatCnt;
  logic             r_valid;
  logic             r_overrun;
  logic [15:0]      r_spawnCount;

  logic [15:0]      w_lfsr;
  logic             w_unusedLfsr;
  shape_code_t      w_raw;
  shape_code_t      w_cand;
  logic             w_tickEn;
  logic             w_expire;
  logic             w_xfer;
  logic             w_gen;
  logic             w_overrunSet;

  galois_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .taps  (LFSR_TAPS),
    .value (w_lfsr)
  );

  assign w_raw        = w_lfsr[SHAPE_CODE_W-1:0];
  assign w_unusedLfsr = ^w_lfsr[15:SHAPE_CODE_W];
  assign w_cand       = limitRepeat(w_raw, r_lastCode, r_repeatCnt, MAX_REP);

  // A period of 0 behaves like 1; ">=" lets a shortened period expire on the very next tick.
  assign w_effLast    = (spawn_period == '0) ? '0 : spawn_period - CNT_W'(1);
  assign w_tickEn     = tick & run;
  assign w_expire     = w_tickEn & (r_cnt >= w_effLast);
  assign w_xfer       = r_valid & code_ready;
  assign w_gen        = (r_state == COUNT) & w_expire;
  assign w_overrunSet = (r_state == PRESENT) & w_expire & ~w_xfer;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (!run) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_nextState = (r_valid && !w_xfer) ? PRESENT : COUNT;
        COUNT:   if (w_expire) w_nextState = PRESENT;
        PRESENT: if (w_xfer) w_nextState = COUNT;
        default: w_nextState = IDLE;
      endcase
    end
    // While a code is pending the counter parks at the last step so the next tick after acceptance spawns.
    if (w_tickEn && (r_state != IDLE)) begin
      if (!w_expire) begin
        w_nextCnt = r_cnt + CNT_W'(1);
      end else if (r_state == COUNT) begin
        w_nextCnt = '0;
      end else begin
        w_nextCnt = w_effLast;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_code       <= '0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_spawnCount <= '0;
      r_lastCode   <= '0;
      r_repeatCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (w_overrunSet) begin
        r_overrun <= 1'b1;
      end
      if (w_xfer) begin
        r_valid      <= 1'b0;
        r_spawnCount <= r_spawnCount + 16'd1;
      end
      if (w_gen) begin
        r_code      <= w_cand;
        r_valid     <= 1'b1;
        r_lastCode  <= w_cand;
        r_repeatCnt <= (w_cand == r_lastCode) ? r_repeatCnt + 3'd1 : 3'd1;
      end
    end
  end

  assign code_out    = r_code;
  assign code_valid  = r_valid;
  assign overrun     = r_overrun;
  assign spawn_count = r_spawnCount;

endmodule

// File: tb/tb_asteroid_code_generator.sv
// Directed bench for asteroid_code_generator: vector table plus hand-written repeat/overrun/reset sequences.
module tb_asteroid_code_generator;
  import asteroid_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        tick;
  logic [7:0]  spawnPeriod;
  logic        codeReady;
  shape_code_t codeOut;
  logic        codeValid;
  logic        overrun;
  logic [15:0] spawnCount;

  int total = 0;
  int bad   = 0;

  logic [15:0] mLfsr;
  shape_code_t mLast;
  shape_code_t mExpCode;
  logic [2:0]  mRep;

  typedef struct packed {
    logic        run;
    logic        tick;
    logic [7:0]  per;
    logic        ready;
    logic        gen;
    logic        expValid;
    logic        expOverrun;
    logic [15:0] expCount;
    logic        chkCode;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  asteroid_code_generator dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .tick         (tick),
    .spawn_period (spawnPeriod),
    .code_ready   (codeReady),
    .code_out     (codeOut),
    .code_valid   (codeValid),
    .overrun      (overrun),
    .spawn_count  (spawnCount)
  );

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // When gen is set, the expected code comes from the LFSR value the DUT sees at this edge.
  task automatic applyStimulus(input logic iRst, input logic iRun, input logic iTick,
                               input logic [7:0] iPer, input logic iReady, input logic iGen);
    shape_code_t raw;
    shape_code_t cand;
    rst         = iRst;
    run         = iRun;
    tick        = iTick;
    spawnPeriod = iPer;
    codeReady   = iReady;
    if (iGen) begin
      raw  = mLfsr[2:0];
      cand = (raw == mLast && mRep == 3'd2) ? raw + 3'd1 : raw;
      mRep = (cand == mLast) ? mRep + 3'd1 : 3'd1;
      mLast    = cand;
      mExpCode = cand;
    end
    @(posedge clk);
    #1;
    if (iRst) begin
      mLfsr = 16'hACE1;
      mLast = 3'd0;
      mRep  = 3'd0;
    end else begin
      mLfsr = lfsrStep(mLfsr);
    end
  endtask

  task automatic addVec(input logic r, input logic t, input logic [7:0] p, input logic rd,
                        input logic g, input logic ev, input logic eo,
                        input logic [15:0] ec, input logic cc);
    vec_t v;
    v.run = r; v.tick = t; v.per = p; v.ready = rd; v.gen = g;
    v.expValid = ev; v.expOverrun = eo; v.expCount = ec; v.chkCode = cc;
    vecs.push_back(v);
  endtask

  initial begin
    shape_code_t expList [3];
    int k;
    int cool;

    expList[0] = 3'd3;
    expList[1] = 3'd3;
    expList[2] = 3'd4;
    rst = 1'b1; run = 1'b0; tick = 1'b0; spawnPeriod = 8'd3; codeReady = 1'b0;
    mLfsr = 16'h0; mLast = 3'd0; mRep = 3'd0; mExpCode = 3'd0;

    // Reset state and the first LFSR steps with the game stopped.
    applyStimulus(1, 0, 0, 8'd3, 0, 0);
    applyStimulus(1, 0, 0, 8'd3, 0, 0);
    checkOutput("rst_valid", 16'(codeValid), 16'd0);
    checkOutput("rst_code", 16'(codeOut), 16'd0);
    checkOutput("rst_overrun", 16'(overrun), 16'd0);
    checkOutput("rst_count", spawnCount, 16'd0);
    checkOutput("lfsr0", dut.w_lfsr, 16'hACE1);
    applyStimulus(0, 0, 0, 8'd3, 0, 0);
    checkOutput("lfsr1", dut.w_lfsr, 16'hE270);
    applyStimulus(0, 0, 1, 8'd3, 0, 0);
    checkOutput("lfsr2", dut.w_lfsr, 16'h7138);
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, 0, (i % 4) == 0, 8'd3, 0, 0);
      checkOutput($sformatf("idle_valid%0d", i), 16'(codeValid), 16'd0);
    end

    // Period 3, tick every 4 cycles, consumer always ready; then period 0.
    addVec(1, 0, 8'd3, 1, 0, 0, 0, 16'd0, 0);
    for (int s = 0; s < 2; s++) begin
      for (int t = 0; t < 2; t++) begin
        addVec(1, 1, 8'd3, 1, 0, 0, 0, 16'(s), 0);
        repeat (3) addVec(1, 0, 8'd3, 1, 0, 0, 0, 16'(s), 0);
      end
      addVec(1, 1, 8'd3, 1, 1, 1, 0, 16'(s), 1);
      repeat (3) addVec(1, 0, 8'd3, 1, 0, 0, 0, 16'(s + 1), 0);
    end
    addVec(1, 1, 8'd0, 1, 1, 1, 0, 16'd2, 1);
    addVec(1, 1, 8'd0, 1, 0, 0, 0, 16'd3, 0);
    addVec(1, 1, 8'd0, 1, 1, 1, 0, 16'd3, 1);
    addVec(1, 0, 8'd0, 1, 0, 0, 0, 16'd4, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].run, vecs[i].tick, vecs[i].per, vecs[i].ready, vecs[i].gen);
      checkOutput($sformatf("vec%0d_valid", i), 16'(codeValid), 16'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_overrun", i), 16'(overrun), 16'(vecs[i].expOverrun));
      checkOutput($sformatf("vec%0d_count", i), spawnCount, vecs[i].expCount);
      if (vecs[i].chkCode) begin
        checkOutput($sformatf("vec%0d_code", i), 16'(codeOut), 16'(mExpCode));
      end
    end

    // Repeat limiter: tick only when the LFSR presents raw code 3.
    applyStimulus(1, 0, 0, 8'd1, 1, 0);
    applyStimulus(0, 1, 0, 8'd1, 1, 0);
    k = 0;
    cool = 0;
    for (int c = 0; c < 3000 && k < 3; c++) begin
      if (cool == 0 && mLfsr[2:0] == 3'd3) begin
        applyStimulus(0, 1, 1, 8'd1, 1, 1);
        checkOutput($sformatf("rep%0d_valid", k), 16'(codeValid), 16'd1);
        checkOutput($sformatf("rep%0d_code", k), 16'(codeOut), 16'(expList[k]));
        k++;
        cool = 1;
      end else begin
        applyStimulus(0, 1, 0, 8'd1, 1, 0);
        if (cool > 0) cool--;
      end
    end
    checkOutput("rep_found", 16'(k), 16'd3);
    applyStimulus(0, 1, 0, 8'd1, 1, 0);
    checkOutput("rep_count", spawnCount, 16'd3);
    checkOutput("rep_valid_end", 16'(codeValid), 16'd0);

    // Consumer stalls across two intervals, then accepts.
    applyStimulus(0, 1, 1, 8'd2, 0, 0);
    checkOutput("ovr_a_valid", 16'(codeValid), 16'd0);
    applyStimulus(0, 1, 1, 8'd2, 0, 1);
    checkOutput("ovr_b_valid", 16'(codeValid), 16'd1);
    checkOutput("ovr_b_code", 16'(codeOut), 16'(mExpCode));
    applyStimulus(0, 1, 1, 8'd2, 0, 0);
    checkOutput("ovr_c_overrun", 16'(overrun), 16'd0);
    checkOutput("ovr_c_code", 16'(codeOut), 16'(mExpCode));
    applyStimulus(0, 1, 1, 8'd2, 0, 0);
    checkOutput("ovr_d_overrun", 16'(overrun), 16'd1);
    checkOutput("ovr_d_code", 16'(codeOut), 16'(mExpCode));
    applyStimulus(0, 1, 1, 8'd2, 0, 0);
    checkOutput("ovr_e_overrun", 16'(overrun), 16'd1);
    checkOutput("ovr_e_valid", 16'(codeValid), 16'd1);
    checkOutput("ovr_e_code", 16'(codeOut), 16'(mExpCode));
    checkOutput("ovr_e_cnt", 16'(dut.r_cnt), 16'd1);
    applyStimulus(0, 1, 0, 8'd2, 1, 0);
    checkOutput("ovr_f_valid", 16'(codeValid), 16'd0);
    checkOutput("ovr_f_count", spawnCount, 16'd4);
    applyStimulus(0, 1, 1, 8'd2, 0, 1);
    checkOutput("ovr_g_valid", 16'(codeValid), 16'd1);
    checkOutput("ovr_g_code", 16'(codeOut), 16'(mExpCode));
    checkOutput("ovr_g_count", spawnCount, 16'd4);

    // Reset while a code is pending.
    applyStimulus(1, 1, 0, 8'd2, 0, 0);
    checkOutput("mid_rst_valid", 16'(codeValid), 16'd0);
    checkOutput("mid_rst_count", spawnCount, 16'd0);
    checkOutput("mid_rst_overrun", 16'(overrun), 16'd0);
    checkOutput("mid_rst_code", 16'(codeOut), 16'd0);
    checkOutput("mid_rst_lfsr", dut.w_lfsr, 16'hACE1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asteroid_code_generator.md
Name: asteroid_code_generator

Overview:
Produces the 3-bit asteroid shape codes consumed by the 3-bit-to-7-bit shape decoder: the encoding-side source of that interface. A free-running 16-bit Galois LFSR supplies the entropy. A frame-tick-driven interval counter decides when to spawn. Each code is offered on a valid/ready handshake to the playfield row loader, and a repeat limiter stops one shape from dominating.

Parameters:
LFSR_SEED, 16'hACE1, LFSR value after reset; must be nonzero (a zero seed is replaced by 16'h0001).
LFSR_TAPS, 16'hB400, Galois feedback mask for right-shift LFSR.
MAX_REPEAT, 2, maximum consecutive identical codes emitted (range 1..7).
CNT_W, 8, width of spawn interval counter and spawn_period port.

Ports:
clk  input  1  system clock.
rst  input  1  reset.
run  input  1  game running; 0 freezes the interval counter.
tick  input  1  one-cycle frame tick; the interval counter advances only on tick.
spawn_period  input  CNT_W  ticks between spawns; 0 treated as 1.
code_ready  input  1  consumer accepts code this cycle.
code_out  output  3  shape code to decoder.
code_valid  output  1  code_out holds a new unconsumed code.
overrun  output  1  sticky: a spawn interval expired while a code was still pending.
spawn_count  output  16  number of codes accepted, wraps at 16'hFFFF -> 0.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Sampled only on the rising edge of clk.
- Reset values: code_out=0, code_valid=0, overrun=0, spawn_count=0, interval counter=0, lfsr=LFSR_SEED, last_code=0, repeat_cnt=0, state=IDLE.
- LFSR advances every clk cycle regardless of run, tick or state (except in reset): next = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
- States:
  - IDLE: entered from reset. Moves to COUNT when run=1.
  - COUNT: on tick and run, if counter == eff_period-1 then counter<=0 and generate; otherwise counter increments.
  - PRESENT: code_valid=1.
  - From any state, run=0 moves to IDLE and the counter holds its value. A pending code stays valid and still transfers.
- Generate (same cycle):
  - raw = lfsr[2:0].
  - If raw == last_code and repeat_cnt == MAX_REPEAT, then cand = raw+1 mod 8; otherwise cand = raw.
  - code_out <= cand; code_valid <= 1 on the next edge (1-cycle latency from the expiring tick). Enter PRESENT.
  - repeat_cnt <= (cand == last_code) ? repeat_cnt+1 : 1. last_code <= cand.
- Handshake:
  - Transfer when code_valid & code_ready.
  - code_out is stable while code_valid=1 and unaccepted.
  - On transfer: code_valid <= 0, spawn_count increments, return to COUNT (or IDLE if run=0).
  - code_ready while code_valid=0 is ignored.
- Interval expiry while in PRESENT (tick, run, counter == eff_period-1):
  - No new code is generated; the pending code is kept.
  - overrun <= 1 (cleared only by rst).
  - Counter holds at eff_period-1, so generation happens on the first tick after acceptance.
- Transfer and expiry in the same cycle: the transfer takes priority, overrun is not set, and the counter holds for the next tick.
- spawn_period change mid-interval takes effect immediately. If counter >= new eff_period-1, the next tick expires.
- Reset mid-PRESENT discards the pending code; code_valid=0 the next cycle.

Decomposition:
- Shared package asteroid_pkg: SHAPE_CODE_W=3, the default LFSR seed/taps constants, and the shape_code_t typedef (also used by the decoder).
- Sub-module galois_lfsr16 (clk, rst, seed, taps, value): reusable for other random game elements. The state machine, counter and repeat limiter stay in the top module.

Test Plan:
- Reset release, run=0 for 20 cycles -> code_valid=0; LFSR sequence 16'hACE1, 16'hE270, 16'h7138 on consecutive cycles.
- run=1, spawn_period=3, code_ready=1, tick every 4 cycles -> code_valid pulses one cycle after every 3rd tick; code_out == model lfsr[2:0]; spawn_count 0->1->2.
- Force identical raw codes (tick aligned to LFSR phase yielding raw=3 three times), MAX_REPEAT=2 -> emitted codes 3,3,4.
- code_ready=0 across two intervals -> code_out stable, overrun=1, counter holds; assert code_ready -> accepted, next code on the following tick.
- spawn_period=0 -> spawn on every tick; transfer and expiry in the same cycle -> overrun stays 0.
- rst asserted while code_valid=1 -> next cycle code_valid=0, spawn_count=0, lfsr=16'hACE1.
